// File: rtl/rule_cfg_loader.sv
// rule_cfg_loader: turns host config packets (header + addr/data pairs) into single-cycle rule-write strobes.
// Latency: immediate mode strobes 1 cycle after each data word; commit mode replays N pairs in N cycles after eop.
// Backpressure: o_cfg_ready drops only while a committed packet is being replayed, otherwise every word is taken.
module rule_cfg_loader #(
   parameter logic [15:0] MAGIC     = 16'h5A5A,
   parameter int          BUF_DEPTH = 16,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cfg_valid,
   input  logic [31:0]          i_cfg_data,
   input  logic                 i_cfg_sop,
   input  logic                 i_cfg_eop,
   output logic                 o_cfg_ready,
   output logic                 o_rule_wren,
   output logic [31:0]          o_rule_addr,
   output logic [31:0]          o_rule_wdata,
   output logic [CNT_WIDTH-1:0] o_pkt_ok_cnt,
   output logic [CNT_WIDTH-1:0] o_pkt_err_cnt,
   output logic                 o_busy
);

   localparam int         PW      = $clog2(BUF_DEPTH);
   localparam logic [8:0] DEPTH_W = 9'(BUF_DEPTH);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, DROP, REPLAY} state_t;

   typedef struct packed {
      logic [15:0] magic;
      logic [7:0]  cmd;
      logic [7:0]  n;
   } hdr_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } pair_t;

   state_t      state, state_nxt;
   hdr_t        hdr;
   pair_t       pair_buf [BUF_DEPTH];
   logic [7:0]  rem;
   logic [7:0]  rem_dec;
   logic        commit_mode;
   logic [31:0] pend_addr;
   logic [PW:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic        accept;
   logic        hdr_good;
   logic        abort;

   logic        load_hdr, latch_addr, push, issue, replay_out, ptr_clr, ok_inc;
   logic [1:0]  err_inc;

   assign hdr         = i_cfg_data;
   assign o_cfg_ready = (state != REPLAY);
   assign o_busy      = (state != IDLE);
   assign accept      = i_cfg_valid && o_cfg_ready;
   assign rem_dec     = rem - 8'd1;
   assign abort       = (state == ADDR) || (state == DATA);
   assign hdr_good    = (hdr.magic == MAGIC) && (hdr.n != 8'd0) &&
                        ((hdr.cmd == 8'h01) || ((hdr.cmd == 8'h02) && ({1'b0, hdr.n} <= DEPTH_W)));

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c, input logic [1:0] inc);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
      return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
   endfunction

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next state and per-cycle control decisions
   always_comb begin
      state_nxt  = state;
      load_hdr   = 1'b0;
      latch_addr = 1'b0;
      push       = 1'b0;
      issue      = 1'b0;
      replay_out = 1'b0;
      ptr_clr    = 1'b0;
      ok_inc     = 1'b0;
      err_inc    = 2'd0;
      if (state == REPLAY) begin
         replay_out = 1'b1;
         if (({1'b0, rd_ptr} + (PW+1)'(1)) == wr_ptr) begin
            ok_inc    = 1'b1;
            ptr_clr   = 1'b1;
            state_nxt = IDLE;
         end
      end else if (accept && i_cfg_sop) begin
         // a header always restarts parsing; an interrupted packet costs one error
         ptr_clr = 1'b1;
         if (hdr_good && !i_cfg_eop) begin
            err_inc   = {1'b0, abort};
            load_hdr  = 1'b1;
            state_nxt = ADDR;
         end else begin
            err_inc   = {1'b0, abort} + 2'd1;
            state_nxt = (!hdr_good && !i_cfg_eop) ? DROP : IDLE;
         end
      end else if (accept) begin
         case (state)
            ADDR: begin
               latch_addr = 1'b1;
               if (i_cfg_eop) begin
                  err_inc   = 2'd1;
                  ptr_clr   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
               end
            end
            DATA: begin
               if (commit_mode) push = 1'b1;
               else             issue = 1'b1;
               if (rem_dec == 8'd0) begin
                  if (i_cfg_eop) begin
                     ok_inc    = !commit_mode;
                     state_nxt = commit_mode ? REPLAY : IDLE;
                  end else begin
                     err_inc   = 2'd1;
                     ptr_clr   = 1'b1;
                     state_nxt = DROP;
                  end
               end else if (i_cfg_eop) begin
                  err_inc   = 2'd1;
                  ptr_clr   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = ADDR;
               end
            end
            DROP: begin
               if (i_cfg_eop) state_nxt = IDLE;
            end
            default: ;
         endcase
      end
   end

   // datapath: counters, pointers, pending address and rule-write outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rem           <= 8'd0;
         commit_mode   <= 1'b0;
         pend_addr     <= 32'd0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         o_rule_wren   <= 1'b0;
         o_rule_addr   <= 32'd0;
         o_rule_wdata  <= 32'd0;
         o_pkt_ok_cnt  <= '0;
         o_pkt_err_cnt <= '0;
      end else begin
         if (load_hdr) begin
            rem         <= hdr.n;
            commit_mode <= (hdr.cmd == 8'h02);
         end else if (push || issue) begin
            rem <= rem_dec;
         end
         if (latch_addr) pend_addr <= i_cfg_data;
         // a clear outranks a push so an aborted commit packet leaves nothing behind
         if (ptr_clr)   wr_ptr <= '0;
         else if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (ptr_clr)         rd_ptr <= '0;
         else if (replay_out) rd_ptr <= rd_ptr + PW'(1);
         o_rule_wren <= issue || replay_out;
         if (issue) begin
            o_rule_addr  <= pend_addr;
            o_rule_wdata <= i_cfg_data;
         end else if (replay_out) begin
            o_rule_addr  <= pair_buf[rd_ptr].addr;
            o_rule_wdata <= pair_buf[rd_ptr].data;
         end
         if (ok_inc)          o_pkt_ok_cnt  <= sat_add(o_pkt_ok_cnt, 2'd1);
         if (err_inc != 2'd0) o_pkt_err_cnt <= sat_add(o_pkt_err_cnt, err_inc);
      end
   end

   // commit-mode pair storage; contents are only meaningful below wr_ptr
   always_ff @(posedge i_clk) begin
      if (push) pair_buf[wr_ptr[PW-1:0]] <= '{addr: pend_addr, data: i_cfg_data};
   end

endmodule

// File: doc/rule_cfg_loader.md
Name: rule_cfg_loader

Overview:
- Upstream feeder of the parser/deparser rule-configuration stage.
- Accepts 32b configuration packets from the host control stream and converts them into single-cycle rule-write strobes (wren/addr/wdata) for the rule configurator.
- Supports two modes:
  - immediate mode: each write is issued as soon as its pair arrives.
  - atomic commit mode: pairs are buffered and replayed only if the whole packet is well-formed, so a malformed packet never leaves a partial rule set.

Parameters:
- MAGIC, 16'h5A5A, required value of header bits [31:16].
- BUF_DEPTH, 16, commit-mode pair buffer depth (power of 2, ≥2).
- CNT_WIDTH, 16, width of the status counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cfg_valid  in  1  input word valid
- i_cfg_data  in  32  input word
- i_cfg_sop  in  1  first word of packet
- i_cfg_eop  in  1  last word of packet
- o_cfg_ready  out  1  loader accepts a word this cycle
- o_rule_wren  out  1  one-cycle write strobe to the rule configurator
- o_rule_addr  out  32  write address
- o_rule_wdata  out  32  write data
- o_pkt_ok_cnt  out  CNT_WIDTH  packets completed without error (saturating)
- o_pkt_err_cnt  out  CNT_WIDTH  packets dropped or aborted (saturating)
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- A word is accepted when i_cfg_valid and o_cfg_ready are both high.
- o_cfg_ready is high in every state except REPLAY.
- Packet format:
  - Word 0 is the header: [31:16] = MAGIC, [15:8] = cmd (8'h01 immediate, 8'h02 commit), [7:0] = N, the pair count.
  - Words 1..2N alternate: address word, then data word.
- Reset values: all outputs 0; FSM in IDLE; buffer pointers 0.
- FSM states: IDLE, ADDR, DATA, DROP, REPLAY.
- IDLE:
  - Accepted word with sop=1: the header is checked.
  - Header is good when magic matches, cmd is 01 or 02, N≠0, and (cmd==02 implies N≤BUF_DEPTH). A good header loads the remaining-pair counter with N and goes to ADDR.
  - If a good header also has eop=1, it is an error: err_cnt +1, stay in IDLE.
  - Bad header: err_cnt +1, then go to DROP (or stay in IDLE if eop=1).
  - Accepted word with sop=0: discarded silently; no counter change.
- ADDR: the accepted word is latched as the pending address, then go to DATA.
- DATA: on the accepted word, the remaining-pair counter decrements.
  - Immediate mode: next cycle o_rule_wren=1 with o_rule_addr = pending address and o_rule_wdata = word (latency 1 cycle).
  - Commit mode: the {addr, data} pair is written to the buffer.
  - If the counter reaches 0 and eop=1:
    - Immediate mode: ok_cnt +1, go to IDLE.
    - Commit mode: go to REPLAY.
  - If the counter is still >0, go to ADDR.
- Early eop (eop=1 in ADDR, or in DATA with counter >0 after the decrement):
  - err_cnt +1, go to IDLE.
  - Commit buffer is discarded (write pointer cleared); no strobes are issued.
  - Writes already issued in immediate mode stand.
- Late eop (counter reaches 0 and eop=0): err_cnt +1, go to DROP.
  - In commit mode the buffer is discarded.
  - In immediate mode the writes already issued stand.
- sop=1 on any accepted word outside IDLE:
  - The current packet is aborted: err_cnt +1, buffer cleared.
  - The word is then processed as a new header in the same cycle, exactly as in IDLE.
- DROP: words are consumed until an accepted word with eop=1, then go to IDLE. sop within DROP is handled as above, without a second error count for the dropped packet.
- REPLAY:
  - One buffered pair per cycle: o_rule_wren=1 with the pair's addr/data. o_rule_wren is never high for two pairs in the same cycle.
  - After the last pair: ok_cnt +1, pointers cleared, go to IDLE.
  - Replay of N pairs takes exactly N cycles; o_cfg_ready=0 throughout.
- o_rule_addr/o_rule_wdata hold their last values when o_rule_wren=0.
- Counters saturate at all-ones and do not wrap.
- Reset asserted at any time: all state clears immediately; a partially replayed packet is abandoned and not counted.

Test Plan:
- Immediate, good packet: hdr 5A5A_01_02, pairs (0001_0000,1), (0001_0203,0x00AB_0000) with eop on last word → two wren pulses, each 1 cycle after its data word; ok_cnt=1, err_cnt=0.
- Commit, good packet: hdr 5A5A_02_03, 3 pairs, eop on last → no wren during input; then 3 consecutive wren cycles in input order; o_cfg_ready=0 for exactly 3 cycles; ok_cnt=1.
- Commit, early eop: hdr 5A5A_02_03, eop asserted on the 2nd data word → zero wren pulses; err_cnt=1; FSM back in IDLE; a following good packet loads normally.
- Bad magic: hdr 1234_01_01 followed by 2 words, eop on last → no wren, err_cnt=1, next packet accepted.
- Commit overflow: hdr with N=BUF_DEPTH+1 (5A5A_02_11) → dropped to eop, err_cnt=1; hdr with N=16 → 16 replay strobes.
- Mid-packet sop: immediate hdr N=2, one pair, then a new sop header 5A5A_01_01 plus one pair with eop → exactly 2 wren total, err_cnt=1, ok_cnt=1. Separately, reset pulsed during REPLAY → outputs 0, remaining strobes suppressed.
